// File: rtl/feram_ctrl_pkg.sv
// rtl/feram_ctrl_pkg.sv - shared FSM encoding, requester ids and row geometry
// Used by the FeRAM row arbiter, its interface and its round-robin sub-block.
package feram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } feram_state_t;

  localparam logic REQ_AES = 1'b0;
  localparam logic REQ_KEY = 1'b1;

  localparam int BYTES_PER_ROW = 4;

  function automatic int row_width(input int data_w);
    return data_w * BYTES_PER_ROW;
  endfunction

endpackage

// File: rtl/feram_row_arbiter_if.sv
// rtl/feram_row_arbiter_if.sv - requester, response and row-memory signal bundle
// The slave modport is the arbiter's view; master is the requester/memory side.
interface feram_row_arbiter_if
  import feram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);

  localparam int ROW_W = row_width(DATA_W);

  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_row;
  logic [2*ROW_W-1:0]  req_wdata;
  logic [1:0]          req_ready;

  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [ROW_W-1:0]    rsp_rdata;
  logic                rsp_err;

  logic                mem_sra_en;
  logic [ADDR_W-1:0]   mem_row_addr;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_wr_row;
  logic [ROW_W-1:0]    mem_wr_data;
  logic [ROW_W-1:0]    mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_row, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_sra_en, mem_row_addr, mem_wr_en, mem_wr_row, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_row, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_sra_en, mem_row_addr, mem_wr_en, mem_wr_row, mem_wr_data
  );

endinterface

// File: rtl/feram_rr_arb2.sv
// rtl/feram_rr_arb2.sv - two-way round-robin arbiter with last-grant pointer
// The pointer resets to the key requester so the AES datapath wins first.
module feram_rr_arb2
  import feram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_KEY;
    end else if (advance && (gnt != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last == REQ_KEY) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/feram_row_arbiter.sv
// rtl/feram_row_arbiter.sv - two-requester FeRAM row arbiter with read restore
// One transaction in flight: accept, row read/capture or write, then response.
module feram_row_arbiter
  import feram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int N_ROWS  = 16,
  parameter int RESTORE = 1
)(
  input  logic                clk,
  input  logic                rst,
  feram_row_arbiter_if.slave  bus,
  output logic                busy
);

  localparam int              ROW_W     = row_width(DATA_W);
  localparam logic [ADDR_W:0] LP_N_ROWS = (ADDR_W + 1)'(N_ROWS);

  feram_state_t      r_state;
  feram_state_t      w_next;

  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_accept;
  logic              w_sel_idx;
  logic              w_sel_we;
  logic              w_sel_oor;
  logic [ADDR_W-1:0] w_sel_row;
  logic [ROW_W-1:0]  w_sel_wdata;

  logic              r_idx;
  logic              r_err;
  logic [ADDR_W-1:0] r_row;
  logic [ROW_W-1:0]  r_wdata;
  logic [ROW_W-1:0]  r_rdata;

  feram_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Gating with rst keeps req_ready low for the whole reset pulse, not just after it.
  assign w_idle        = (r_state == ST_IDLE) && !rst;
  assign bus.req_ready = w_idle ? w_gnt : 2'b00;
  assign w_accept      = w_idle && ((bus.req_valid & w_gnt) != 2'b00);

  assign w_sel_idx   = w_gnt[1];
  assign w_sel_we    = (w_sel_idx == REQ_KEY) ? bus.req_we[1] : bus.req_we[0];
  assign w_sel_row   = (w_sel_idx == REQ_KEY) ? bus.req_row[ADDR_W +: ADDR_W]
                                              : bus.req_row[0 +: ADDR_W];
  assign w_sel_wdata = (w_sel_idx == REQ_KEY) ? bus.req_wdata[ROW_W +: ROW_W]
                                              : bus.req_wdata[0 +: ROW_W];
  assign w_sel_oor   = ({1'b0, w_sel_row} >= LP_N_ROWS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.mem_sra_en   = 1'b0;
    bus.mem_row_addr = '0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wr_row   = '0;
    bus.mem_wr_data  = '0;
    bus.rsp_valid    = 2'b00;
    bus.rsp_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel_oor) begin
            w_next = ST_RESP;
          end else if (w_sel_we) begin
            w_next = ST_WRITE;
          end else begin
            w_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        bus.mem_sra_en   = 1'b1;
        bus.mem_row_addr = r_row;
        w_next           = ST_CAPT;
      end
      ST_CAPT: begin
        // The SRA read is destructive, so the captured word goes straight back.
        if (RESTORE != 0) begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_row  = r_row;
          bus.mem_wr_data = bus.mem_rd_data;
        end
        w_next = ST_RESP;
      end
      ST_WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_row  = r_row;
        bus.mem_wr_data = r_wdata;
        w_next          = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = (r_idx == REQ_KEY) ? 2'b10 : 2'b01;
        bus.rsp_err   = r_err;
        if (bus.rsp_ready[r_idx]) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= REQ_AES;
      r_err   <= 1'b0;
      r_row   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_idx   <= w_sel_idx;
      r_err   <= w_sel_oor;
      r_row   <= w_sel_row;
      r_wdata <= w_sel_wdata;
      r_rdata <= '0;
    end else if (r_state == ST_CAPT) begin
      r_rdata <= bus.mem_rd_data;
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: doc/feram_row_arbiter.md
FERAM_ROW_ARBITER -- requirements
Module: feram_row_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, row-address width.
REQ-002 Parameter DATA_W, default 8, byte width; row word is DATA_W*4 bits.
REQ-003 Parameter N_ROWS, default 16, number of valid rows (0..N_ROWS-1).
REQ-004 Parameter RESTORE, default 1, 1 = write back each read row (destructive-read restore).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  2  per-requester request valid (bit0 = AES datapath, bit1 = key/host loader).
REQ-008 req_we  in  2  per-requester op: 1 = row write, 0 = SRA row read.
REQ-009 req_row  in  2*ADDR_W  per-requester row address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  2*DATA_W*4  per-requester write word, requester i at bits [i*DATA_W*4 +: DATA_W*4].
REQ-011 req_ready  out  2  per-requester accept; request transfers when valid&ready in the same cycle.
REQ-012 rsp_valid  out  2  one-hot response valid to the granted requester.
REQ-013 rsp_ready  in  2  per-requester response accept.
REQ-014 rsp_rdata  out  DATA_W*4  read word (0 for writes and errors), shared by both requesters.
REQ-015 rsp_err  out  1  qualifies rsp_valid: request row >= N_ROWS.
REQ-016 mem_sra_en, mem_row_addr (ADDR_W), mem_wr_en, mem_wr_row (ADDR_W), mem_wr_data (DATA_W*4)  out  FeRAM row-memory command port.
REQ-017 mem_rd_data  in  DATA_W*4  registered memory read word, valid the cycle after mem_sra_en.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, READ, CAPT, WRITE, RESP; exactly one transaction in flight.
REQ-020 req_ready is nonzero only in IDLE and is one-hot to the arbitration winner.
REQ-021 Arbitration is round-robin: one requester valid -> it wins; both valid -> the requester not granted last wins; the last-grant pointer updates only on an accepted handshake.
REQ-022 On accept, latch requester index, we, row, wdata; next state READ (read), WRITE (write), or RESP with rsp_err=1 (row >= N_ROWS, no memory access).
REQ-023 READ: mem_sra_en=1 and mem_row_addr=latched row for exactly one cycle; next CAPT.
REQ-024 CAPT: capture mem_rd_data into rsp_rdata; if RESTORE=1, mem_wr_en=1, mem_wr_row=latched row, mem_wr_data=mem_rd_data in the same cycle; next RESP.
REQ-025 WRITE: mem_wr_en=1, mem_wr_row=latched row, mem_wr_data=latched wdata for one cycle; next RESP.
REQ-026 RESP: rsp_valid[idx]=1, holding rsp_rdata/rsp_err stable until rsp_ready[idx]=1; then IDLE.
REQ-027 Latency, with accept at cycle T: read -> sra_en T+1, restore T+2, rsp_valid from T+3; write -> wr_en T+1, rsp_valid from T+2; error -> rsp_valid from T+1.
REQ-028 rsp_ready from the non-granted requester is ignored; a requester may hold req_valid while another transaction is in flight.
REQ-029 A new request is accepted at the earliest in the cycle after RESP completes, because IDLE is re-entered then.
REQ-030 mem_sra_en and mem_wr_en are never high outside READ, CAPT and WRITE; when inactive, command addr/data outputs are 0.

Reset
REQ-031 Reset asserted, including mid-transaction: state=IDLE; req_ready, rsp_valid, rsp_err, busy, mem_sra_en and mem_wr_en = 0; rsp_rdata, mem addr/data = 0; last-grant pointer = 1, so requester 0 wins first.
REQ-032 An in-flight transaction aborted by reset produces no response and no further memory command.

Structure
REQ-033 Shared package feram_ctrl_pkg holds the FSM state encoding, requester-index constants (REQ_AES=0, REQ_KEY=1) and the row-word width DATA_W*4.
REQ-034 Round-robin logic is a sub-module feram_rr_arb2 (req[1:0], advance -> gnt[1:0], last-grant pointer register).

Verification
REQ-035 Write then read: req0 writes row 3 = 0xA1B2C3D4, then reads row 3 -> rsp_rdata=0xA1B2C3D4, rsp_err=0; read rsp_valid at T+3, sra_en at T+1, restore wr_en at T+2 to row 3 with the same data.
REQ-036 Contention: both valid every cycle from reset -> grants 0,1,0,1 across four transactions.
REQ-037 Out of range: req1 reads row 16 -> no mem_sra_en/mem_wr_en, rsp_valid[1] at T+1, rsp_err=1, rsp_rdata=0.
REQ-038 Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready=0 and busy=1 throughout.
REQ-039 Reset in CAPT of a read -> next cycle all outputs 0 and state IDLE; after release, req0 wins first.
REQ-040 RESTORE=0: read row 5 -> sra_en pulse only, no mem_wr_en in CAPT.
